config_cmd_decoder: RTL and testbench

CONFIG_CMD_DECODER -- requirements
Module: config_cmd_decoder

---
 rtl/config_cmd_decoder.sv | 159 +++++++++++++++
 tb/tb_config_cmd_decoder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/config_cmd_decoder.sv
// rtl/config_cmd_decoder.sv - UDP config command decoder: header/data words to register bus strobes and responses
// Optional build macro: CONFIG_WRITE_ACK_EN (emit a one-word acknowledge after every register write)
module config_cmd_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_ready,
    input  logic [31:0] rx_data,
    input  logic        tx_full,
    output logic        tx_wr,
    output logic [31:0] tx_data,
    output logic [15:0] address,
    output logic        wr,
    output logic        rd,
    output logic [31:0] dout,
    input  logic [31:0] din,
    output logic [7:0]  err_cnt
);

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    typedef enum logic [2:0] {
        IDLE,
        WR_DATA,
        RD_ISSUE,
        RD_WAIT,
        RESP_HDR,
        RESP_DATA
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [3:0]  opcode_q;
    logic [11:0] tag_q;
    logic [15:0] addr_q;
    logic [31:0] dout_q;
    logic [31:0] rdata_q;
    logic        wr_q;
    logic [7:0]  err_q;

    logic        hdr_accept;
    logic        data_accept;
    logic        rdata_capture;
    logic        err_inc;
    logic        push;

    // State register; reset abandons whatever command is in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and per-state datapath enables
    always_comb begin
        state_nxt     = state;
        hdr_accept    = 1'b0;
        data_accept   = 1'b0;
        rdata_capture = 1'b0;
        err_inc       = 1'b0;
        push          = 1'b0;
        case (state)
            IDLE: begin
                if (rx_ready) begin
                    case (rx_data[31:28])
                        OP_WRITE: begin
                            hdr_accept = 1'b1;
                            state_nxt  = WR_DATA;
                        end
                        OP_READ: begin
                            hdr_accept = 1'b1;
                            state_nxt  = RD_ISSUE;
                        end
                        default: err_inc = 1'b1;
                    endcase
                end
            end
            WR_DATA: begin
                if (rx_ready) begin
                    data_accept = 1'b1;
`ifdef CONFIG_WRITE_ACK_EN
                    state_nxt   = RESP_HDR;
`else
                    state_nxt   = IDLE;
`endif
                end
            end
            RD_ISSUE: begin
                err_inc   = rx_ready;
                state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                err_inc       = rx_ready;
                rdata_capture = 1'b1;
                state_nxt     = RESP_HDR;
            end
            RESP_HDR: begin
                err_inc = rx_ready;
                if (!tx_full) begin
                    push      = 1'b1;
                    // a write acknowledge is header-only
                    state_nxt = (opcode_q == OP_WRITE) ? IDLE : RESP_DATA;
                end
            end
            RESP_DATA: begin
                err_inc = rx_ready;
                if (!tx_full) begin
                    push      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Command fields, write data, read data and the saturating error counter
    always_ff @(posedge clk) begin
        if (reset) begin
            opcode_q <= 4'h0;
            tag_q    <= 12'h000;
            addr_q   <= 16'h0000;
            dout_q   <= 32'h0;
            rdata_q  <= 32'h0;
            wr_q     <= 1'b0;
            err_q    <= 8'h00;
        end else begin
            wr_q <= data_accept;
            if (hdr_accept) begin
                opcode_q <= rx_data[31:28];
                tag_q    <= rx_data[27:16];
                addr_q   <= rx_data[15:0];
            end
            if (data_accept) begin
                dout_q <= rx_data;
            end
            if (rdata_capture) begin
                rdata_q <= din;
            end
            if (err_inc && (err_q != 8'hFF)) begin
                err_q <= err_q + 8'h01;
            end
        end
    end

    // Outputs are held at zero for every cycle reset is high, not just after the edge
    assign tx_wr   = push & ~reset;
    assign tx_data = reset                 ? 32'h0 :
                     (state == RESP_HDR)   ? {opcode_q, tag_q, addr_q} :
                     (state == RESP_DATA)  ? rdata_q : 32'h0;
    assign rd      = (state == RD_ISSUE) & ~reset;
    assign wr      = wr_q & ~reset;
    assign address = reset ? 16'h0000 : addr_q;
    assign dout    = reset ? 32'h0 : dout_q;
    assign err_cnt = reset ? 8'h00 : err_q;

endmodule

// File: tb/tb_config_cmd_decoder.sv
// tb/tb_config_cmd_decoder.sv - randomized and directed bench for config_cmd_decoder against a transaction model
module tb_config_cmd_decoder;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rx_ready = 1'b0;
    logic [31:0] rx_data = 32'h0;
    logic        tx_full = 1'b0;
    logic        tx_wr;
    logic [31:0] tx_data;
    logic [15:0] address;
    logic        wr;
    logic        rd;
    logic [31:0] dout;
    logic [31:0] din = 32'h0;
    logic [7:0]  err_cnt;

    always #5 clk = ~clk;

    config_cmd_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .rx_ready (rx_ready),
        .rx_data  (rx_data),
        .tx_full  (tx_full),
        .tx_wr    (tx_wr),
        .tx_data  (tx_data),
        .address  (address),
        .wr       (wr),
        .rd       (rd),
        .dout     (dout),
        .din      (din),
        .err_cnt  (err_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Transaction model: 0 = waiting for header, 1 = waiting for write data,
    // 2 = busy with a fixed pre-push delay followed by a queue of words to send.
    int          m_mode = 0;
    int          m_delay = 0;
    logic [31:0] m_q[$];
    logic [31:0] m_hdr = 32'h0;
    logic [15:0] m_addr = 16'h0;
    logic [31:0] m_dout = 32'h0;
    int          m_err = 0;
    bit          m_wr = 1'b0;
    int          tx_seen = 0;
    int          wr_seen = 0;

    task automatic model_clear();
        m_mode  = 0;
        m_delay = 0;
        m_q.delete();
        m_hdr   = 32'h0;
        m_addr  = 16'h0;
        m_dout  = 32'h0;
        m_err   = 0;
        m_wr    = 1'b0;
    endtask

    task automatic bump_err();
        if (m_err < 255) m_err++;
    endtask

    task automatic cycle(input bit r, input bit rdy, input logic [31:0] d,
                         input bit full, input logic [31:0] di);
        bit          e_rd;
        bit          e_tx;
        logic [31:0] e_txd;
        bit          wr_next;
        @(posedge clk);
        #1;
        reset    = r;
        rx_ready = rdy;
        rx_data  = d;
        tx_full  = full;
        din      = di;
        @(negedge clk);
        if (r) model_clear();
        e_rd  = (m_mode == 2) && (m_delay == 2);
        e_tx  = (m_mode == 2) && (m_delay == 0) && !full && (m_q.size() > 0);
        e_txd = e_tx ? m_q[0] : 32'h0;
        check("wr", wr, m_wr);
        check("rd", rd, e_rd);
        check("tx_wr", tx_wr, e_tx);
        if (e_tx || r) check("tx_data", tx_data, e_txd);
        check("address", address, m_addr);
        check("dout", dout, m_dout);
        check("err_cnt", err_cnt, m_err);
        if (tx_wr) tx_seen++;
        if (wr) wr_seen++;
        if (!r) begin
            wr_next = 1'b0;
            case (m_mode)
                0: if (rdy) begin
                    if (d[31:28] == 4'h1) begin
                        m_hdr  = d;
                        m_addr = d[15:0];
                        m_mode = 1;
                    end else if (d[31:28] == 4'h2) begin
                        m_hdr   = d;
                        m_addr  = d[15:0];
                        m_mode  = 2;
                        m_delay = 2;
                        m_q.delete();
                        m_q.push_back(d);
                    end else begin
                        bump_err();
                    end
                end
                1: if (rdy) begin
                    wr_next = 1'b1;
                    m_dout  = d;
`ifdef CONFIG_WRITE_ACK_EN
                    m_mode  = 2;
                    m_delay = 0;
                    m_q.delete();
                    m_q.push_back(m_hdr);
`else
                    m_mode  = 0;
`endif
                end
                default: begin
                    if (rdy) bump_err();
                    if (m_delay > 0) begin
                        if (m_delay == 1) m_q.push_back(di);
                        m_delay--;
                    end else if (!full) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_mode = 0;
                    end
                end
            endcase
            m_wr = wr_next;
        end
    endtask

    task automatic idle(input int n, input logic [31:0] di);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'h0, 1'b0, di);
    endtask

    initial begin
        logic [31:0] word;
        int          sel;

        repeat (3) cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        check("reset_err", err_cnt, 8'h00);

        // write command
        wr_seen = 0;
        tx_seen = 0;
        cycle(1'b0, 1'b1, 32'h1ABC0010, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0);
        idle(4, 32'h0);
        check("wr_pulses", wr_seen, 1);
`ifdef CONFIG_WRITE_ACK_EN
        check("write_ack_words", tx_seen, 1);
`else
        check("write_tx_words", tx_seen, 0);
`endif

        // read command
        tx_seen = 0;
        cycle(1'b0, 1'b1, 32'h20070004, 1'b0, 32'h12345678);
        idle(6, 32'h12345678);
        check("read_tx_words", tx_seen, 2);

        // read with the response FIFO full for ten cycles
        tx_seen = 0;
        cycle(1'b0, 1'b1, 32'h2123BEEF, 1'b0, 32'h0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hCAFE0001);
        check("full_tx_words", tx_seen, 0);
        idle(5, 32'h0);
        check("full_tx_after", tx_seen, 2);

        // bad opcode plus three words dropped during a read
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h70000000, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h20010002, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, $urandom, 1'b1, 32'h55AA55AA);
        idle(4, 32'h0);
        check("err_four", err_cnt, 8'd4);

        // reset while waiting for read data, then a normal write
        tx_seen = 0;
        cycle(1'b0, 1'b1, 32'h20450123, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        idle(4, 32'h0);
        check("reset_abandon_tx", tx_seen, 0);
        cycle(1'b0, 1'b1, 32'h10450077, 1'b0, 32'h0);
        cycle(1'b0, 1'b1, 32'h0BADF00D, 1'b0, 32'h0);
        idle(3, 32'h0);

        // error counter saturation
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b1, 32'h30000000 | $urandom_range(0, 65535), 1'b0, 32'h0);
        check("err_sat", err_cnt, 8'hFF);

        // randomized traffic
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        for (int i = 0; i < 3000; i++) begin
            word = $urandom;
            sel  = $urandom_range(0, 9);
            if (sel < 4)      word[31:28] = 4'h1;
            else if (sel < 8) word[31:28] = 4'h2;
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, word,
                  $urandom_range(0, 3) == 0, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
